// File: rtl/fsm_step_sequencer_if.sv
// Host command port of the step sequencer.
//   cmd_valid : host offers a command
//   cmd_ready : sequencer can accept (FIFO not full and out of INIT)
//   cmd_ab    : {a,b} levels to hold on the target while the command runs
//   cmd_len   : hold length in cycles, 0 behaves as 1
// master = host side, slave = sequencer side.
interface fsm_step_sequencer_if #(
  parameter int LEN_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_ab;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_ab, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ab, input cmd_len, output cmd_ready);
endinterface

// File: rtl/fsm_step_sequencer.sv
// Step sequencer for a small target FSM (inputs en/a/b, outputs s/bs/f).
// Commands {a,b,len} are queued in a FIFO and replayed onto the target with
// en=1 for len cycles each, back-to-back when the queue has more. A watchdog
// (no s/bs activity) and a terminal-state detector (f) abort the active
// command and put the target through a reset pulse.
// Ports:
//   clk, rst         clock, async active-low reset
//   cmd              command port (slave side of fsm_step_sequencer_if)
//   tgt_rst/en/a/b   registered drive to the target
//   tgt_s/bs/f       target status
//   busy             state is not IDLE
//   done             1-cycle pulse after a command completes normally
//   err_tmo          sticky watchdog flag
//   err_stuck        sticky terminal-state flag
//   err_clr          clears both sticky flags (a same-cycle set wins)
//   rec_count        number of recoveries, saturating at 255
//
// state   | meaning
// INIT    | target held in reset for RST_CYC cycles after reset release
// IDLE    | target quiet, waiting for a queued command
// DRIVE   | replaying the latched command onto the target
// RECOVER | active command aborted, target held in reset for RST_CYC cycles
module fsm_step_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TMO     = 16,
  parameter int RST_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_step_sequencer_if.slave  cmd,
  output logic                 tgt_rst,
  output logic                 tgt_en,
  output logic                 tgt_a,
  output logic                 tgt_b,
  input  logic                 tgt_s,
  input  logic                 tgt_bs,
  input  logic                 tgt_f,
  output logic                 busy,
  output logic                 done,
  output logic                 err_tmo,
  output logic                 err_stuck,
  input  logic                 err_clr,
  output logic [7:0]           rec_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TMO + 1);
  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam int EW   = 2 + LEN_W;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRIVE, ST_RECOVER} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [1:0]       ab_q, ab_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [7:0]       rec_q, rec_d;
  logic             tgt_rst_q, tgt_rst_d;
  logic             tgt_en_q, tgt_en_d;
  logic             tgt_a_q, tgt_a_d;
  logic             tgt_b_q, tgt_b_d;
  logic             done_q, done_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_stuck_q, err_stuck_d;

  logic             push, pop, empty, full, activity;
  logic             set_tmo, set_stuck, enter_rec;
  logic [AW:0]      occ;
  logic [1:0]       head_ab;
  logic [LEN_W-1:0] head_len, head_len_eff;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occ           = wr_ptr_q - rd_ptr_q;
  assign empty         = (occ == '0);
  assign full          = (occ == (AW+1)'(DEPTH));
  assign cmd.cmd_ready = !full && (state_q != ST_INIT);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign {head_ab, head_len} = mem_q[rd_ptr_q[AW-1:0]];
  assign head_len_eff  = (head_len == '0) ? LEN_W'(1) : head_len;
  assign activity      = tgt_s | tgt_bs;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd.cmd_ab, cmd.cmd_len};
  end

  always_comb begin
    state_d   = state_q;
    ab_d      = ab_q;
    rem_d     = rem_q;
    wd_d      = wd_q;
    rc_d      = rc_q;
    rec_d     = rec_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    set_tmo   = 1'b0;
    set_stuck = 1'b0;
    enter_rec = 1'b0;

    case (state_q)
      ST_INIT, ST_RECOVER: begin
        if (rc_q == '0) state_d = ST_IDLE;
        else            rc_d    = rc_q - RC_W'(1);
      end
      ST_IDLE: begin
        if (tgt_f) begin
          set_stuck = 1'b1;
          enter_rec = 1'b1;
        end else if (!empty) begin
          pop     = 1'b1;
          ab_d    = head_ab;
          rem_d   = head_len_eff;
          wd_d    = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Errors take precedence over completion, so no done and no pop.
        if (tgt_f) begin
          set_stuck = 1'b1;
          enter_rec = 1'b1;
        end else if (!activity && (wd_q == WD_W'(TMO - 1))) begin
          set_tmo   = 1'b1;
          enter_rec = 1'b1;
        end else begin
          wd_d = activity ? '0 : wd_q + WD_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_d = 1'b1;
            if (!empty) begin
              pop   = 1'b1;
              ab_d  = head_ab;
              rem_d = head_len_eff;
              wd_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (enter_rec) begin
      state_d = ST_RECOVER;
      rc_d    = RC_W'(RST_CYC - 1);
      if (rec_q != 8'hFF) rec_d = rec_q + 8'd1;
    end

    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    err_tmo_d   = set_tmo   | (err_tmo_q   & ~err_clr);
    err_stuck_d = set_stuck | (err_stuck_q & ~err_clr);

    // Target drive is computed from the next state so it lines up with it.
    tgt_rst_d = (state_d == ST_INIT) || (state_d == ST_RECOVER);
    tgt_en_d  = (state_d == ST_DRIVE);
    tgt_a_d   = tgt_en_d & ab_d[1];
    tgt_b_d   = tgt_en_d & ab_d[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ab_q        <= '0;
      rem_q       <= '0;
      wd_q        <= '0;
      rc_q        <= RC_W'(RST_CYC - 1);
      rec_q       <= '0;
      tgt_rst_q   <= 1'b1;
      tgt_en_q    <= 1'b0;
      tgt_a_q     <= 1'b0;
      tgt_b_q     <= 1'b0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_stuck_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ab_q        <= ab_d;
      rem_q       <= rem_d;
      wd_q        <= wd_d;
      rc_q        <= rc_d;
      rec_q       <= rec_d;
      tgt_rst_q   <= tgt_rst_d;
      tgt_en_q    <= tgt_en_d;
      tgt_a_q     <= tgt_a_d;
      tgt_b_q     <= tgt_b_d;
      done_q      <= done_d;
      err_tmo_q   <= err_tmo_d;
      err_stuck_q <= err_stuck_d;
    end
  end

  assign tgt_rst   = tgt_rst_q;
  assign tgt_en    = tgt_en_q;
  assign tgt_a     = tgt_a_q;
  assign tgt_b     = tgt_b_q;
  assign done      = done_q;
  assign err_tmo   = err_tmo_q;
  assign err_stuck = err_stuck_q;
  assign rec_count = rec_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Bench for fsm_step_sequencer. The watchdog limit is shortened to 12 so a
// single 15-cycle command can run into it.
module tb_fsm_step_sequencer;
  localparam int TMO_TB = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tgt_s = 1'b0, tgt_bs = 1'b0, tgt_f = 1'b0, err_clr = 1'b0;
  logic tgt_rst, tgt_en, tgt_a, tgt_b, busy, done, err_tmo, err_stuck;
  logic [7:0] rec_count;
  bit s_auto = 1'b0;

  int total = 0, bad = 0;
  logic [1:0] exp_drive [$];
  int exp_done [$];
  int cum_drive = 0, drive_seen = 0, done_seen = 0, en_run = 0, last_run = 0;

  fsm_step_sequencer_if #(.LEN_W(4)) cif ();

  fsm_step_sequencer #(.TMO(TMO_TB)) dut (
    .clk(clk), .rst(rst), .cmd(cif),
    .tgt_rst(tgt_rst), .tgt_en(tgt_en), .tgt_a(tgt_a), .tgt_b(tgt_b),
    .tgt_s(tgt_s), .tgt_bs(tgt_bs), .tgt_f(tgt_f),
    .busy(busy), .done(done), .err_tmo(err_tmo), .err_stuck(err_stuck),
    .err_clr(err_clr), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  // Target activity model: s toggles every cycle while enabled.
  always @(negedge clk) tgt_s = s_auto ? ~tgt_s : 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask

  // Scoreboard monitor: pops one expectation per drive cycle and per done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (exp_done.size() == 0) chk("done_unexpected", done, 0);
      else chk("done_position", drive_seen, exp_done.pop_front());
      done_seen++;
    end
    if (tgt_en) begin
      if (exp_drive.size() == 0) chk("drive_unexpected", tgt_en, 0);
      else chk("drive_ab", {tgt_a, tgt_b}, exp_drive.pop_front());
      drive_seen++;
      en_run++;
    end else begin
      if (tgt_a || tgt_b) chk("ab_idle_zero", {tgt_a, tgt_b}, 0);
      if (en_run != 0) begin
        last_run = en_run;
        en_run = 0;
      end
    end
  end

  task automatic push_cmd(input logic [1:0] ab, input logic [3:0] len,
                          input int ndrive, input bit exp_dn);
    int n;
    n = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_ab    = ab;
    cif.cmd_len   = len;
    while (!cif.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cif.cmd_ready) fail_wait("push_ready");
    else begin
      for (int i = 0; i < ndrive; i++) exp_drive.push_back(ab);
      cum_drive += ndrive;
      if (exp_dn) exp_done.push_back(cum_drive);
    end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic count_rst(output int n);
    int w;
    w = 0;
    n = 0;
    while (!tgt_rst && w < 40) begin
      @(negedge clk);
      w++;
    end
    while (tgt_rst && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(busy == 1'b0 && exp_drive.size() == 0 && exp_done.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_wait(name);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, d0;
    cif.cmd_valid = 1'b0;
    cif.cmd_ab    = 2'b00;
    cif.cmd_len   = 4'd0;

    // 1: reset values, INIT length, ready/busy after INIT
    @(negedge clk);
    chk("rst_tgt_rst", tgt_rst, 1);
    chk("rst_tgt_en", tgt_en, 0);
    chk("rst_ab", {tgt_a, tgt_b}, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_tmo, err_stuck}, 0);
    chk("rst_rec", rec_count, 0);
    chk("rst_ready", cif.cmd_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("init_ready", cif.cmd_ready, 0);
    count_rst(n);
    chk("init_rst_cycles", n, 2);
    chk("idle_ready", cif.cmd_ready, 1);
    chk("idle_busy", busy, 0);
    s_auto = 1'b1;

    // 2: single command, latency and done
    d0 = done_seen;
    push_cmd(2'b10, 4'd3, 3, 1'b1);
    chk("lat_n1_en", tgt_en, 0);
    @(negedge clk);
    chk("lat_n2_en", tgt_en, 1);
    wait_idle("t2_idle");
    chk("t2_run", last_run, 3);
    chk("t2_dones", done_seen - d0, 1);
    chk("t2_busy", busy, 0);

    // 3a: four back-to-back commands, zero length treated as one
    d0 = done_seen;
    push_cmd(2'b01, 4'd1, 1, 1'b1);
    push_cmd(2'b11, 4'd2, 2, 1'b1);
    push_cmd(2'b10, 4'd0, 1, 1'b1);
    push_cmd(2'b01, 4'd5, 5, 1'b1);
    wait_idle("t3a_idle");
    chk("t3a_run", last_run, 9);
    chk("t3a_dones", done_seen - d0, 4);

    // 3b: fill the FIFO behind a long command
    d0 = done_seen;
    push_cmd(2'b11, 4'd15, 15, 1'b1);
    push_cmd(2'b00, 4'd1, 1, 1'b1);
    push_cmd(2'b01, 4'd1, 1, 1'b1);
    push_cmd(2'b10, 4'd1, 1, 1'b1);
    push_cmd(2'b11, 4'd1, 1, 1'b1);
    chk("t3b_full_ready", cif.cmd_ready, 0);
    push_cmd(2'b01, 4'd2, 2, 1'b1);
    wait_idle("t3b_idle");
    chk("t3b_run", last_run, 21);
    chk("t3b_dones", done_seen - d0, 6);

    // 4: watchdog expiry with no target activity
    s_auto = 1'b0;
    @(negedge clk);
    d0 = done_seen;
    push_cmd(2'b01, 4'd15, TMO_TB, 1'b0);
    count_rst(n);
    chk("t4_rst_cycles", n, 2);
    chk("t4_err_tmo", err_tmo, 1);
    chk("t4_err_stuck", err_stuck, 0);
    chk("t4_rec", rec_count, 1);
    chk("t4_run", last_run, TMO_TB);
    chk("t4_no_done", done_seen - d0, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4_clr", err_tmo, 0);
    s_auto = 1'b1;

    // 5: tgt_f on the final drive cycle
    d0 = done_seen;
    push_cmd(2'b10, 4'd3, 3, 1'b0);
    n = 0;
    while (!tgt_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tgt_en) fail_wait("t5_drive_start");
    repeat (2) @(negedge clk);
    tgt_f = 1'b1;
    @(negedge clk);
    tgt_f = 1'b0;
    count_rst(n);
    chk("t5_rst_cycles", n, 2);
    chk("t5_err_stuck", err_stuck, 1);
    chk("t5_rec", rec_count, 2);
    chk("t5_no_done", done_seen - d0, 0);
    // new tgt_f together with err_clr in IDLE, then tgt_f held into RECOVER
    tgt_f = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_set_wins", err_stuck, 1);
    chk("t5_recover", tgt_rst, 1);
    @(negedge clk);
    tgt_f = 1'b0;
    chk("t5_f_ignored_rec", rec_count, 3);
    @(negedge clk);
    chk("t5_back_idle", busy, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_clr", err_stuck, 0);

    // 6: async reset mid-command with two commands queued
    push_cmd(2'b11, 4'd15, 5, 1'b0);
    push_cmd(2'b01, 4'd2, 0, 1'b0);
    push_cmd(2'b10, 4'd2, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_driving", tgt_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_tgt_rst", tgt_rst, 1);
    chk("t6_tgt_en", tgt_en, 0);
    chk("t6_ab", {tgt_a, tgt_b}, 0);
    chk("t6_ready", cif.cmd_ready, 0);
    chk("t6_rec", rec_count, 0);
    chk("t6_done", done, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    count_rst(n);
    chk("t6_rst_cycles", n, 2);
    repeat (6) @(negedge clk);
    chk("t6_flushed_busy", busy, 0);
    chk("t6_ready_after", cif.cmd_ready, 1);
    chk("t6_run", last_run, 5);
    chk("drive_queue_empty", exp_drive.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
